rc5_job_arbiter: RTL and testbench

Round-robin job controller that shares one `algo` RC5 encrypt/decrypt core between `NREQ` requesters. It accepts a block job from one requester and sequences the core's start pulse, operands and `num_rounds`. It waits for `done` and returns the result to the owning requester over a valid/ready response. It also locks subkeys while a job is in flight and recovers the core with a watchdog if `done` never arrives.

---
 rtl/rc5_pkg.sv | 29 ++
 rtl/rc5_job_arbiter_if.sv | 29 ++
 rtl/rc5_rr_arb.sv | 34 +++
 rtl/rc5_job_arbiter.sv | 140 ++++++++++++++
 tb/tb_rc5_job_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5 job arbiter: controller states,
// operation encodings and the latched job record.
package rc5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } rc5_ctl_state_t;

  localparam int   RC5_MAX_ROUNDS = 16;
  localparam logic RC5_OP_ENC     = 1'b0;
  localparam logic RC5_OP_DEC     = 1'b1;
  localparam int   RC5_OWNER_W    = 3;

  typedef struct packed {
    logic                   op;
    logic [4:0]             rounds;
    logic [31:0]            data;
    logic [RC5_OWNER_W-1:0] owner;
  } rc5_job_t;

  function automatic logic rc5_rounds_ok(input logic [4:0] rounds);
    return rounds <= 5'(RC5_MAX_ROUNDS);
  endfunction

endpackage

// File: rtl/rc5_job_arbiter_if.sv
// Requester-side job/response bundle for rc5_job_arbiter, one lane per requester.
interface rc5_job_arbiter_if #(
  parameter int NREQ = 2
);

  // A job transfers on a cycle where req_valid[i] & req_ready[i]; a response
  // transfers where rsp_valid[i] & rsp_ready[i]. Valid, once raised, holds
  // with stable payload until the matching ready; ready may depend on valid.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0][4:0]  req_rounds;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_rounds, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_rounds, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rc5_rr_arb.sv
// Combinational round-robin pick: first requester with valid at or above ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its index.
module rc5_rr_arb #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int          j;
  logic [IW-1:0] j_idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      j     = (int'(ptr) + i) % NREQ;
      j_idx = IW'(j);
      if (!any && req[j_idx]) begin
        any          = 1'b1;
        grant[j_idx] = 1'b1;
        idx          = j_idx;
      end
    end
  end

endmodule

// File: rtl/rc5_job_arbiter.sv
// Shares one RC5 core between NREQ requesters: round-robin job acceptance,
// core sequencing, watchdog recovery and per-owner response return.
module rc5_job_arbiter
  import rc5_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst,
  rc5_job_arbiter_if.slave bus,
  input  logic            key_ready,
  output logic            subkey_lock,
  output logic            core_rst_n,
  output logic            core_encrypt,
  output logic            core_decrypt,
  output logic [4:0]      core_num_rounds,
  output logic [31:0]     core_d_in,
  input  logic [31:0]     core_d_out,
  input  logic            core_done,
  output rc5_ctl_state_t  dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  rc5_ctl_state_t  state;
  rc5_job_t        job;
  logic [IW-1:0]   ptr;
  logic [WW-1:0]   wd;
  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;
  logic            core_rst_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic [IW-1:0]   ptr_nx;
  logic [NREQ-1:0] owner_oh;
  logic            acc_op;
  logic [4:0]      acc_rounds;
  logic [31:0]     acc_data;

  rc5_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign accept     = (state == ST_IDLE) && key_ready && gnt_any;
  assign ptr_nx     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign owner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << job.owner[IW-1:0];
  assign acc_op     = bus.req_op[gnt_idx];
  assign acc_rounds = bus.req_rounds[gnt_idx];
  assign acc_data   = bus.req_data[gnt_idx];

  assign bus.req_ready = ((state == ST_IDLE) && key_ready && !rst) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // Start pulses decode the registered state, so they are exactly one ISSUE cycle wide.
  assign core_encrypt    = (state == ST_ISSUE) && (job.op == RC5_OP_ENC);
  assign core_decrypt    = (state == ST_ISSUE) && (job.op == RC5_OP_DEC);
  assign core_num_rounds = job.rounds;
  assign core_d_in       = job.data;
  assign core_rst_n      = core_rst_q && !rst;
  assign subkey_lock     = (state != ST_IDLE);
  assign dbg_state       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      job         <= '0;
      ptr         <= '0;
      wd          <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      core_rst_q  <= 1'b1;
    end else begin
      core_rst_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            job.op     <= acc_op;
            job.rounds <= acc_rounds;
            job.data   <= acc_data;
            job.owner  <= RC5_OWNER_W'(gnt_idx);
            ptr        <= ptr_nx;
            if (rc5_rounds_ok(acc_rounds)) begin
              state <= ST_ISSUE;
            end else begin
              // Over-long jobs never reach the core; answer with an error directly.
              state       <= ST_RESP;
              rsp_valid_q <= gnt;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_BUSY;
          wd    <= '0;
        end
        ST_BUSY: begin
          if (core_done) begin
            state       <= ST_RESP;
            rsp_valid_q <= owner_oh;
            rsp_data_q  <= core_d_out;
            rsp_err_q   <= 1'b0;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            state      <= ST_RECOVER;
            core_rst_q <= 1'b0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_RECOVER: begin
          state       <= ST_RESP;
          rsp_valid_q <= owner_oh;
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready[job.owner[IW-1:0]]) begin
            state       <= ST_IDLE;
            rsp_valid_q <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_job_arbiter.sv
// Bench for rc5_job_arbiter: behavioural RC5-16 core, scripted requesters and
// a response scoreboard keyed on {err, owner, data}.
module tb_rc5_job_arbiter;
  import rc5_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           key_ready, subkey_lock, core_rst_n, core_encrypt, core_decrypt;
  logic [4:0]     core_num_rounds;
  logic [31:0]    core_d_in, core_d_out;
  logic           core_done;
  rc5_ctl_state_t dbg_state;

  rc5_job_arbiter_if #(.NREQ(NREQ)) bus ();

  rc5_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .key_ready(key_ready), .subkey_lock(subkey_lock),
    .core_rst_n(core_rst_n), .core_encrypt(core_encrypt), .core_decrypt(core_decrypt),
    .core_num_rounds(core_num_rounds), .core_d_in(core_d_in), .core_d_out(core_d_out),
    .core_done(core_done), .dbg_state(dbg_state)
  );

  // ---------------- RC5-16 software model ----------------
  logic [15:0] sk [0:33];

  function automatic logic [15:0] rol16(input logic [15:0] x, input logic [3:0] s);
    logic [31:0] t;
    t = {x, x} << s;
    return t[31:16];
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] x, input logic [3:0] s);
    logic [31:0] t;
    t = {x, x} >> s;
    return t[15:0];
  endfunction

  task automatic key_expand();
    logic [15:0] l [0:3];
    logic [15:0] a, b;
    int i, j;
    for (int k = 0; k < 4; k++) l[k] = 16'h0;
    sk[0] = 16'hB7E1;
    for (int k = 1; k < 34; k++) sk[k] = sk[k-1] + 16'h9E37;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 3 * 34; k++) begin
      sk[i] = rol16(sk[i] + a + b, 4'd3);
      a = sk[i];
      l[j] = rol16(l[j] + a + b, 4'(a + b));
      b = l[j];
      i = (i + 1) % 34;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [31:0] rc5_enc(input logic [31:0] d, input logic [4:0] r);
    logic [15:0] a, b;
    a = d[15:0] + sk[0];
    b = d[31:16] + sk[1];
    for (int i = 1; i <= int'(r); i++) begin
      a = rol16(a ^ b, b[3:0]) + sk[2*i];
      b = rol16(b ^ a, a[3:0]) + sk[2*i+1];
    end
    return {b, a};
  endfunction

  function automatic logic [31:0] rc5_dec(input logic [31:0] d, input logic [4:0] r);
    logic [15:0] a, b;
    a = d[15:0];
    b = d[31:16];
    for (int i = int'(r); i >= 1; i--) begin
      b = ror16(b - sk[2*i+1], a[3:0]) ^ a;
      a = ror16(a - sk[2*i], b[3:0]) ^ b;
    end
    return {b - sk[1], a - sk[0]};
  endfunction

  // ---------------- behavioural core ----------------
  logic        stuck;
  logic        cm_busy, cm_done;
  logic [4:0]  cm_rem;
  logic [31:0] cm_res;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      cm_busy <= 1'b0;
      cm_done <= 1'b0;
      cm_rem  <= '0;
    end else if (core_encrypt || core_decrypt) begin
      cm_busy <= 1'b1;
      cm_rem  <= core_num_rounds;
      cm_res  <= core_decrypt ? rc5_dec(core_d_in, core_num_rounds) : rc5_enc(core_d_in, core_num_rounds);
      cm_done <= (core_num_rounds == 5'd0) && !stuck;
    end else if (cm_done) begin
      cm_done <= 1'b0;
      cm_busy <= 1'b0;
    end else if (cm_busy) begin
      if (cm_rem <= 5'd1 && !stuck) cm_done <= 1'b1;
      cm_rem <= cm_rem - 5'd1;
    end
  end
  assign core_done  = cm_done;
  assign core_d_out = cm_done ? cm_res : 32'h0;

  int pulse_cnt = 0, rst_low_cnt = 0, rst_low_cyc = 0;
  always @(negedge clk) begin
    if (core_encrypt || core_decrypt) pulse_cnt <= pulse_cnt + 1;
    if (!core_rst_n && !rst) begin
      rst_low_cnt <= rst_low_cnt + 1;
      rst_low_cyc <= cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q [$];
  int n_cmp = 0, n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int owner_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 7;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int r, output int t_acc);
    logic ok;
    ok = 1'b0;
    t_acc = cyc;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (bus.req_ready[r]) begin
        ok = 1'b1;
        t_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    check_val($sformatf("accept_r%0d", r), 64'(ok), 64'd1);
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic start_job(input int r, input logic op, input logic [4:0] rounds,
                           input logic [31:0] data, input logic err, input logic [31:0] edata,
                           output int t_acc);
    @(negedge clk);
    bus.req_op[r]     = op;
    bus.req_rounds[r] = rounds;
    bus.req_data[r]   = data;
    bus.req_valid[r]  = 1'b1;
    exp_q.push_back({err, 3'(r), edata});
    wait_accept(r, t_acc);
  endtask

  task automatic finish_job(input int r, input int t_acc, input int exp_lat, input int hold,
                            output logic [31:0] got_data);
    logic ok, stable, noacc;
    logic [31:0] d0, od;
    logic [35:0] e;
    int o;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.rsp_valid[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val($sformatf("rsp_wait_r%0d", r), 64'(ok), 64'd1);
    if (exp_lat >= 0) check_val("latency", 64'(cyc - t_acc), 64'(exp_lat));
    if (hold > 0) begin
      o = 1 - r;
      od = $urandom();
      d0 = bus.rsp_data;
      stable = 1'b1;
      noacc = 1'b1;
      bus.req_op[o] = 1'b0;
      bus.req_rounds[o] = 5'd3;
      bus.req_data[o] = od;
      bus.req_valid[o] = 1'b1;
      exp_q.push_back({1'b0, 3'(o), rc5_enc(od, 5'd3)});
      for (int h = 0; h < hold; h++) begin
        #1;
        if (bus.req_ready[o]) noacc = 1'b0;
        @(negedge clk);
        if (!bus.rsp_valid[r] || bus.rsp_data !== d0) stable = 1'b0;
      end
      check_val("hold_stable", 64'(stable), 64'd1);
      check_val("hold_no_accept", 64'(noacc), 64'd1);
    end
    check_val("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 36'h0;
    check_val("rsp", {28'h0, bus.rsp_err, 3'(owner_of(bus.rsp_valid)), bus.rsp_data}, {28'h0, e});
    got_data = bus.rsp_data;
    bus.rsp_ready[r] = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- contention ----------------
  task automatic rr_contention();
    int sent [2];
    int exp_grant, resp_cnt, pend;
    logic in_job, lock_ok;
    logic [35:0] e;
    sent[0] = 0; sent[1] = 0;
    exp_grant = 0; resp_cnt = 0; pend = -1; in_job = 1'b0; lock_ok = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      bus.req_op[r] = 1'b0;
      bus.req_rounds[r] = 5'd1;
      bus.req_data[r] = $urandom();
      bus.req_valid[r] = 1'b1;
    end
    for (int k = 0; k < 300 && resp_cnt < 8; k++) begin
      if (pend >= 0) begin
        sent[pend]++;
        if (sent[pend] < 4) bus.req_data[pend] = $urandom();
        else bus.req_valid[pend] = 1'b0;
        pend = -1;
      end
      #1;
      if (in_job && !subkey_lock) lock_ok = 1'b0;
      if (bus.req_ready != '0) begin
        check_val("rr_grant", 64'(owner_of(bus.req_ready)), 64'(exp_grant));
        exp_q.push_back({1'b0, 3'(exp_grant), rc5_enc(bus.req_data[exp_grant], 5'd1)});
        pend = owner_of(bus.req_ready);
        exp_grant = 1 - exp_grant;
        in_job = 1'b1;
      end
      if (bus.rsp_valid != '0) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 36'h0;
        check_val("rr_rsp", {28'h0, bus.rsp_err, 3'(owner_of(bus.rsp_valid)), bus.rsp_data}, {28'h0, e});
        resp_cnt++;
        in_job = 1'b0;
      end
      @(negedge clk);
    end
    check_val("rr_resp_count", 64'(resp_cnt), 64'd8);
    check_val("rr_lock", 64'(lock_ok), 64'd1);
    bus.req_valid = '0;
  endtask

  // ---------------- main sequence ----------------
  int t, pc0, rl0;
  logic [31:0] d, got, c, p;
  logic gate_ok;

  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_rounds = '0;
    bus.req_data = '0;
    bus.rsp_ready = '1;
    key_ready = 1'b1;
    stuck = 1'b0;
    rst = 1'b1;
    key_expand();
    repeat (3) @(negedge clk);
    bus.req_valid = '1;
    #1;
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check_val("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check_val("rst_lock", 64'(subkey_lock), 64'd0);
    check_val("rst_pulses", 64'({core_encrypt, core_decrypt}), 64'd0);
    check_val("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check_val("rst_rounds", 64'(core_num_rounds), 64'd0);
    check_val("rst_d_in", 64'(core_d_in), 64'd0);
    check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    rr_contention();

    pc0 = pulse_cnt;
    start_job(0, 1'b0, 5'd12, 32'h0, 1'b0, rc5_enc(32'h0, 5'd12), t);
    finish_job(0, t, 15, 0, got);
    check_val("enc12_pulses", 64'(pulse_cnt - pc0), 64'd1);

    d = $urandom();
    start_job(1, 1'b0, 5'd0, d, 1'b0, {d[31:16] + sk[1], d[15:0] + sk[0]}, t);
    finish_job(1, t, 3, 0, got);

    d = $urandom();
    start_job(0, 1'b0, 5'd16, d, 1'b0, rc5_enc(d, 5'd16), t);
    finish_job(0, t, 19, 0, got);

    pc0 = pulse_cnt;
    start_job(1, 1'b0, 5'd17, $urandom(), 1'b1, 32'h0, t);
    finish_job(1, t, 1, 0, got);
    check_val("rej_no_pulse", 64'(pulse_cnt - pc0), 64'd0);

    stuck = 1'b1;
    rl0 = rst_low_cnt;
    start_job(1, 1'b0, 5'd5, $urandom(), 1'b1, 32'h0, t);
    finish_job(1, t, TIMEOUT + 3, 0, got);
    check_val("to_rst_pulses", 64'(rst_low_cnt - rl0), 64'd1);
    check_val("to_rst_time", 64'(rst_low_cyc - t), 64'(TIMEOUT + 2));
    stuck = 1'b0;
    d = $urandom();
    start_job(1, 1'b0, 5'd3, d, 1'b0, rc5_enc(d, 5'd3), t);
    finish_job(1, t, 6, 0, got);

    // key gating: requests parked while subkeys are not ready
    key_ready = 1'b0;
    @(negedge clk);
    d = $urandom();
    bus.req_op[0] = 1'b1;
    bus.req_rounds[0] = 5'd4;
    bus.req_data[0] = d;
    bus.req_valid[0] = 1'b1;
    exp_q.push_back({1'b0, 3'd0, rc5_dec(d, 5'd4)});
    gate_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.req_ready != '0) gate_ok = 1'b0;
      @(negedge clk);
    end
    check_val("key_gate", 64'(gate_ok), 64'd1);
    key_ready = 1'b1;
    wait_accept(0, t);
    finish_job(0, t, 7, 0, got);

    bus.rsp_ready[0] = 1'b0;
    d = $urandom();
    start_job(0, 1'b0, 5'd2, d, 1'b0, rc5_enc(d, 5'd2), t);
    finish_job(0, t, 5, 5, got);
    wait_accept(1, t);
    finish_job(1, t, 6, 0, got);

    p = $urandom();
    start_job(0, 1'b0, 5'd8, p, 1'b0, rc5_enc(p, 5'd8), t);
    finish_job(0, t, 11, 0, c);
    start_job(1, 1'b1, 5'd8, c, 1'b0, p, t);
    finish_job(1, t, 11, 0, got);
    check_val("round_trip", 64'(got), 64'(p));

    start_job(0, 1'b0, 5'd16, $urandom(), 1'b0, 32'h0, t);
    @(negedge clk);
    check_val("mid_state_busy", 64'(dbg_state), 64'(ST_BUSY));
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check_val("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("mid_rst_lock", 64'(subkey_lock), 64'd0);
    check_val("mid_rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check_val("mid_rst_outs", {bus.rsp_err, core_num_rounds, bus.rsp_data, 26'h0}, 64'd0);
    check_val("mid_rst_d_in", 64'(core_d_in), 64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    rst = 1'b0;
    d = $urandom();
    start_job(1, 1'b0, 5'd1, d, 1'b0, rc5_enc(d, 5'd1), t);
    finish_job(1, t, 4, 0, got);
    check_val("q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
